// File: rtl/ahbl_sram_slave.sv
// ahbl_sram_slave: AHB-Lite subordinate backed by a word-wide SRAM with byte/half/word access and fixed wait states.
// Define AHBL_SLV_ERR_EN to answer illegal transfers with the two-cycle ERROR response.
module ahbl_sram_slave #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_DEPTH   = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                  clk_cpu,
    input  logic                  rstn_cpu,
    input  logic                  hsel_i,
    input  logic [ADDR_WIDTH-1:0] haddr_i,
    input  logic [1:0]            htrans_i,
    input  logic [2:0]            hsize_i,
    input  logic                  hwrite_i,
    input  logic [2:0]            hburst_i,
    input  logic [3:0]            hprot_i,
    input  logic                  hmastlock_i,
    input  logic [DATA_WIDTH-1:0] hwdata_i,
    input  logic                  hready_i,
    output logic [DATA_WIDTH-1:0] hrdata_o,
    output logic                  hreadyout_o,
    output logic                  hresp_o
);
    localparam int IW = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(MEM_DEPTH) << 2;

`ifdef AHBL_SLV_ERR_EN
    typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;
`else
    typedef enum logic [1:0] {IDLE, WAIT, DATA} state_t;
`endif

    state_t                state, nxt;
    logic [2:0]            cnt, cnt_nxt;
    logic                  rdy, rdy_nxt;
    logic [ADDR_WIDTH-1:0] offset;
    logic                  oor, odd, take, we;
    logic [IW-1:0]         widx;
    logic [1:0]            lane, sz;
    logic                  wr, ok;
    logic [3:0]            strb;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic                  unused;

    assign unused = ^{hburst_i, hprot_i, hmastlock_i, htrans_i[0]};

    assign offset = haddr_i - BASE_ADDR;
    assign oor    = {1'b0, offset} >= SPAN;
    assign odd    = hsize_i[2] || hsize_i[1:0] == 2'b11 || (hsize_i[0] && haddr_i[0])
                    || (hsize_i[1] && haddr_i[1:0] != 2'b00);
    // rdy is our own registered HREADYOUT: low only while we stall the bus
    assign take   = hsel_i && htrans_i[1] && hready_i && rdy;

    always_comb begin
        nxt     = IDLE;
        cnt_nxt = cnt;
        case (state)
            WAIT: begin
                nxt     = cnt == 3'd0 ? DATA : WAIT;
                cnt_nxt = cnt == 3'd0 ? 3'd0 : cnt - 3'd1;
            end
`ifdef AHBL_SLV_ERR_EN
            ERR1: nxt = ERR2;
`endif
            default: nxt = IDLE;
        endcase
        if (take) begin
`ifdef AHBL_SLV_ERR_EN
            nxt = (oor || odd) ? ERR1 : WAIT_STATES == 0 ? DATA : WAIT;
`else
            nxt = WAIT_STATES == 0 ? DATA : WAIT;
`endif
            cnt_nxt = nxt == WAIT ? 3'(WAIT_STATES - 1) : 3'd0;
        end
`ifdef AHBL_SLV_ERR_EN
        rdy_nxt = nxt != WAIT && nxt != ERR1;
`else
        rdy_nxt = nxt != WAIT;
`endif
    end

    always_ff @(posedge clk_cpu or negedge rstn_cpu) begin
        if (!rstn_cpu) begin
            state <= IDLE;
            cnt   <= '0;
            rdy   <= 1'b1;
            widx  <= '0;
            lane  <= '0;
            sz    <= '0;
            wr    <= 1'b0;
            ok    <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
            rdy   <= rdy_nxt;
            if (take) begin
                widx <= offset[IW+1:2];
                lane <= haddr_i[1:0];
                sz   <= odd ? 2'b10 : hsize_i[1:0];
                wr   <= hwrite_i;
                ok   <= !oor;
            end
        end
    end

`ifdef AHBL_SLV_ERR_EN
    always_ff @(posedge clk_cpu or negedge rstn_cpu) begin
        if (!rstn_cpu) hresp_o <= 1'b0;
        else hresp_o <= nxt == ERR1 || nxt == ERR2;
    end
`else
    assign hresp_o = 1'b0;
`endif

    assign hreadyout_o = rdy;

    always_comb
        strb = sz == 2'b00 ? 4'b0001 << lane : sz == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;

    assign we = rstn_cpu && state == DATA && wr && ok;

    always_ff @(posedge clk_cpu) begin
        for (int i = 0; i < 4; i++)
            if (we && strb[i]) mem[widx][8*i +: 8] <= hwdata_i[8*i +: 8];
    end

    // combinational read of the registered index gives read-after-write forwarding for free
    assign hrdata_o = (state == DATA && !wr && ok) ? mem[widx] : '0;
endmodule

// File: tb/tb_ahbl_sram_slave.sv
// tb_ahbl_sram_slave: two slaves (0 and 3 wait states) share one AHB-Lite bus; a scoreboard
// checks every data phase. Compile with AHBL_SLV_ERR_EN to expect ERROR responses.
`timescale 1ns/1ps
module tb_ahbl_sram_slave;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic        sel0, sel3, hwrite, hready;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        ready0, ready3, resp0, resp3;
    logic [31:0] rdata0, rdata3;
    logic        dp_valid, dp_own;

    typedef struct {
        logic [31:0] data;
        logic        resp;
        int          waits;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model0 [int];
    logic [31:0] model3 [int];
    int          checks = 0;
    int          errors = 0;
    int          wcnt = 0;

    ahbl_sram_slave #(.WAIT_STATES(0)) u0 (
        .clk_cpu(clk), .rstn_cpu(rstn), .hsel_i(sel0), .haddr_i(haddr), .htrans_i(htrans),
        .hsize_i(hsize), .hwrite_i(hwrite), .hburst_i(3'd0), .hprot_i(4'd3), .hmastlock_i(1'b0),
        .hwdata_i(hwdata), .hready_i(hready), .hrdata_o(rdata0), .hreadyout_o(ready0), .hresp_o(resp0)
    );

    ahbl_sram_slave #(.WAIT_STATES(3)) u3 (
        .clk_cpu(clk), .rstn_cpu(rstn), .hsel_i(sel3), .haddr_i(haddr), .htrans_i(htrans),
        .hsize_i(hsize), .hwrite_i(hwrite), .hburst_i(3'd0), .hprot_i(4'd3), .hmastlock_i(1'b0),
        .hwdata_i(hwdata), .hready_i(hready), .hrdata_o(rdata3), .hreadyout_o(ready3), .hresp_o(resp3)
    );

    assign hready = dp_own ? ready3 : ready0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dp_valid <= 1'b0;
            dp_own   <= 1'b0;
        end else if (hready) begin
            dp_valid <= (sel0 || sel3) && htrans[1];
            dp_own   <= sel3;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] a, input logic [2:0] s);
        logic [3:0]  m;
        logic [31:0] r;
        r = old;
        m = s == 3'd0 ? 4'b0001 << a : s == 3'd1 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    task automatic xfer(input logic unit3, input logic [31:0] a, input logic [2:0] s,
                        input logic w, input logic [31:0] wd);
        exp_t        e;
        logic        oor, odd, bad;
        logic [31:0] word;
        int          idx;
        oor = a >= 32'h4000;
        odd = s > 3'd2 || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00);
`ifdef AHBL_SLV_ERR_EN
        bad = oor || odd;
`else
        bad = 1'b0;
`endif
        idx  = int'(a[31:2]);
        word = unit3 ? (model3.exists(idx) ? model3[idx] : 32'h0) : (model0.exists(idx) ? model0[idx] : 32'h0);
        e.waits = bad ? 1 : (unit3 ? 3 : 0);
        e.resp  = bad;
        e.data  = (w || bad || oor) ? 32'h0 : word;
        if (w && !bad && !oor) begin
            word = merge(word, wd, a[1:0], odd ? 3'd2 : s);
            if (unit3) model3[idx] = word;
            else model0[idx] = word;
        end
        sel0 = !unit3; sel3 = unit3; haddr = a; htrans = 2'b10; hsize = s; hwrite = w;
        for (int n = 0; n <= 20; n++) begin
            @(negedge clk);
            if (hready) break;
            if (n == 20) begin
                check("accept_hready", 32'(hready), 32'd1);
                return;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1 hwdata = wd;
    endtask

    task automatic idle(input int n);
        sel0 = 1'b0; sel3 = 1'b0; htrans = 2'b00;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rstn) wcnt = 0;
        else begin
            if (!(dp_valid && !dp_own)) begin
                check("idle0_ready", 32'(ready0), 32'd1);
                check("idle0_resp", 32'(resp0), 32'd0);
                check("idle0_rdata", rdata0, 32'd0);
            end
            if (!(dp_valid && dp_own)) begin
                check("idle3_ready", 32'(ready3), 32'd1);
                check("idle3_resp", 32'(resp3), 32'd0);
                check("idle3_rdata", rdata3, 32'd0);
            end
            if (dp_valid) begin
                if (exp_q.size() == 0) check("queue_depth", 32'(exp_q.size()), 32'd1);
                else if (!hready) begin
                    wcnt++;
                    check("stall_resp", 32'(dp_own ? resp3 : resp0), 32'(exp_q[0].resp));
                    check("stall_rdata", dp_own ? rdata3 : rdata0, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wait_cycles", 32'(wcnt), 32'(e.waits));
                    check("resp", 32'(dp_own ? resp3 : resp0), 32'(e.resp));
                    check("rdata", dp_own ? rdata3 : rdata0, e.data);
                    wcnt = 0;
                end
            end
        end
    end

    initial begin
        sel0 = 1'b0; sel3 = 1'b0; haddr = '0; htrans = 2'b00; hsize = 3'd0; hwrite = 1'b0; hwdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready0", 32'(ready0), 32'd1);
        check("rst_resp0", 32'(resp0), 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_ready3", 32'(ready3), 32'd1);
        check("rst_resp3", 32'(resp3), 32'd0);
        check("rst_rdata3", rdata3, 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        // word write then back-to-back read
        xfer(1'b0, 32'h10, 3'd2, 1'b1, 32'hDEAD_BEEF);
        xfer(1'b0, 32'h10, 3'd2, 1'b0, 32'h0);
        // byte and halfword strobes, garbage in unused lanes
        xfer(1'b0, 32'h20, 3'd2, 1'b1, 32'h0000_0000);
        xfer(1'b0, 32'h22, 3'd0, 1'b1, 32'h55AA_5555);
        xfer(1'b0, 32'h20, 3'd2, 1'b0, 32'h0);
        xfer(1'b0, 32'h20, 3'd1, 1'b1, 32'h9999_1234);
        xfer(1'b0, 32'h20, 3'd2, 1'b0, 32'h0);
        xfer(1'b0, 32'h23, 3'd0, 1'b1, 32'h5AFF_FFFF);
        xfer(1'b0, 32'h22, 3'd1, 1'b1, 32'h7788_EEEE);
        xfer(1'b0, 32'h20, 3'd2, 1'b0, 32'h0);
        // wait-state slave, then hand the bus back to the zero-wait slave
        xfer(1'b1, 32'h0, 3'd2, 1'b1, 32'hCAFE_F00D);
        xfer(1'b1, 32'h0, 3'd2, 1'b0, 32'h0);
        xfer(1'b1, 32'h40, 3'd2, 1'b1, 32'h1111_1111);
        xfer(1'b0, 32'h10, 3'd2, 1'b0, 32'h0);
        idle(4);
        // IDLE, BUSY and deselected NONSEQ with hwrite high must not write
        hwdata = 32'h0BAD_0BAD; haddr = 32'h10; hsize = 3'd2; hwrite = 1'b1;
        sel0 = 1'b1; htrans = 2'b00;
        repeat (2) @(posedge clk);
        #1 htrans = 2'b01;
        repeat (2) @(posedge clk);
        #1 sel0 = 1'b0; htrans = 2'b10;
        repeat (2) @(posedge clk);
        #1;
        xfer(1'b0, 32'h10, 3'd2, 1'b0, 32'h0);
        // illegal transfers
        xfer(1'b0, 32'h0, 3'd2, 1'b1, 32'h0102_0304);
        xfer(1'b0, 32'h4000, 3'd2, 1'b0, 32'h0);
        xfer(1'b0, 32'h4000, 3'd2, 1'b1, 32'hFFFF_FFFF);
        xfer(1'b0, 32'h0, 3'd2, 1'b0, 32'h0);
        xfer(1'b0, 32'h11, 3'd2, 1'b1, 32'h4444_4444);
        xfer(1'b0, 32'h10, 3'd2, 1'b0, 32'h0);
        xfer(1'b0, 32'h21, 3'd1, 1'b1, 32'h5555_5555);
        xfer(1'b0, 32'h20, 3'd2, 1'b0, 32'h0);
        xfer(1'b0, 32'h20, 3'd3, 1'b1, 32'h6666_6666);
        xfer(1'b0, 32'h20, 3'd2, 1'b0, 32'h0);
        xfer(1'b1, 32'h4000, 3'd0, 1'b0, 32'h0);
        xfer(1'b1, 32'h40, 3'd2, 1'b0, 32'h0);
        idle(6);
        // reset in the second wait cycle of a write aborts it
        sel3 = 1'b1; haddr = 32'h40; htrans = 2'b10; hsize = 3'd2; hwrite = 1'b1;
        @(negedge clk);
        check("pre_reset_hready", 32'(hready), 32'd1);
        exp_q.push_back('{32'h0, 1'b0, 3});
        @(posedge clk);
        #1 hwdata = 32'h2222_2222; sel3 = 1'b0; htrans = 2'b00;
        @(posedge clk);
        #1 check("wait2_ready3", 32'(ready3), 32'd0);
        rstn = 1'b0;
        exp_q.delete();
        #1;
        check("abort_ready3", 32'(ready3), 32'd1);
        check("abort_resp3", 32'(resp3), 32'd0);
        check("abort_rdata3", rdata3, 32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
        xfer(1'b1, 32'h40, 3'd2, 1'b0, 32'h0);
        xfer(1'b0, 32'h10, 3'd2, 1'b0, 32'h0);
        idle(8);
        check("queue_left", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
